mem_req_sequencer: RTL

//  Synthesizable front-end that replaces the stimulus generator ahead of the 1024x8 memory.

---
 rtl/mem_seq_pkg.sv | 35 +++
 rtl/cmd_fifo.sv | 70 +++++++
 rtl/mem_req_sequencer.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/mem_seq_pkg.sv
// Shared types and defaults for the memory request sequencer.
package mem_seq_pkg;

    localparam int ADDR_W_DEF = 10;
    localparam int DATA_W_DEF = 8;

    // Host command opcodes
    typedef enum logic [1:0] {
        OP_WR  = 2'b00,
        OP_RDA = 2'b01,
        OP_RDB = 2'b10,
        OP_RSV = 2'b11
    } op_e;

    // Sequencer FSM states
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WRITE   = 3'd1,
        ST_RD_STB  = 3'd2,
        ST_RD_WAIT = 3'd3,
        ST_RESP    = 3'd4
    } state_e;

    // Command record at the default memory geometry
    typedef struct packed {
        op_e                   op;
        logic [ADDR_W_DEF-1:0] addr;
        logic [DATA_W_DEF-1:0] data;
    } cmd_t;

    function automatic logic is_read(input op_e op);
        return (op == OP_RDA) || (op == OP_RDB);
    endfunction

endpackage

// File: rtl/cmd_fifo.sv
// Synchronous show-ahead FIFO holding packed host commands.
module cmd_fifo #(
    parameter int WIDTH = 20,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_rdata,
    output logic             o_full,
    output logic             o_empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wptr;
    logic [PTR_W-1:0] r_rptr;
    logic [PTR_W:0]   r_count;
    logic             r_full;
    logic [PTR_W:0]   w_count_nxt;
    logic             w_push;
    logic             w_pop;

    assign w_push  = i_push && !r_full;
    assign w_pop   = i_pop && (r_count != '0);
    assign o_rdata = r_mem[r_rptr];
    assign o_full  = r_full;
    assign o_empty = (r_count == '0);

    // Occupancy after this cycle's push/pop
    always_comb begin
        w_count_nxt = r_count;
        if (w_push && !w_pop) begin
            w_count_nxt = r_count + 1'b1;
        end else if (!w_push && w_pop) begin
            w_count_nxt = r_count - 1'b1;
        end
    end

    // Storage array; contents are don't-care until pointed at
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= i_wdata;
        end
    end

    // Pointers, occupancy and registered full flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_full  <= 1'b0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            r_count <= w_count_nxt;
            r_full  <= (w_count_nxt == FULL_CNT);
        end
    end

endmodule

// File: rtl/mem_req_sequencer.sv
// Host command front-end for the 1024x8 memory: queues commands, drives the
// memory control bus one op at a time and returns read data tagged by port.
module mem_req_sequencer
    import mem_seq_pkg::*;
#(
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int DATA_W     = DATA_W_DEF,
    parameter int FIFO_DEPTH = 4,
    parameter int RD_LAT     = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_data,
    output logic [DATA_W-1:0] validdata,
    output logic [ADDR_W-1:0] iAddress,
    output logic              iWriteEnable,
    output logic              Readtoa,
    output logic              Readtob,
    input  logic [DATA_W-1:0] mem_rdata_a,
    input  logic [DATA_W-1:0] mem_rdata_b,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_port,
    output logic              err_illegal
);

    localparam int CW    = 2 + ADDR_W + DATA_W;
    localparam int CNT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
    localparam logic [CNT_W-1:0] LAT_LAST = CNT_W'(RD_LAT - 1);

    state_e            r_state;
    state_e            w_state_nxt;
    op_e               r_op;
    logic [CNT_W-1:0]  r_lat_cnt;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_rsp_data;
    logic              r_rsp_port;
    logic              r_err;
    logic              r_rdy_en;

    logic              w_push;
    logic              w_pop;
    logic              w_fifo_full;
    logic              w_fifo_empty;
    logic [CW-1:0]     w_fifo_rdata;
    op_e               w_head_op;
    logic [ADDR_W-1:0] w_head_addr;
    logic [DATA_W-1:0] w_head_data;
    logic              w_we;
    logic              w_rda;
    logic              w_rdb;
    logic              w_rsp_valid;
    logic              w_lat_done;

    // r_rdy_en keeps cmd_ready low while in reset; both terms are registered
    assign cmd_ready = r_rdy_en && !w_fifo_full;
    assign w_push    = cmd_valid && cmd_ready;

    assign w_head_op   = op_e'(w_fifo_rdata[CW-1 -: 2]);
    assign w_head_addr = w_fifo_rdata[DATA_W +: ADDR_W];
    assign w_head_data = w_fifo_rdata[DATA_W-1:0];

    cmd_fifo #(
        .WIDTH (CW),
        .DEPTH (FIFO_DEPTH)
    ) u_cmd_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_wdata ({cmd_op, cmd_addr, cmd_data}),
        .i_pop   (w_pop),
        .o_rdata (w_fifo_rdata),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty)
    );

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state, FIFO pop and memory strobes
    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        w_we        = 1'b0;
        w_rda       = 1'b0;
        w_rdb       = 1'b0;
        w_rsp_valid = 1'b0;
        w_lat_done  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (!w_fifo_empty) begin
                    w_pop = 1'b1;
                    if (w_head_op == OP_WR) begin
                        w_state_nxt = ST_WRITE;
                    end else if (is_read(w_head_op)) begin
                        w_state_nxt = ST_RD_STB;
                    end
                end
            end
            ST_WRITE: begin
                w_we        = 1'b1;
                w_state_nxt = ST_IDLE;
            end
            ST_RD_STB: begin
                w_rda       = (r_op == OP_RDA);
                w_rdb       = (r_op == OP_RDB);
                w_state_nxt = ST_RD_WAIT;
            end
            ST_RD_WAIT: begin
                if (r_lat_cnt == LAT_LAST) begin
                    w_lat_done  = 1'b1;
                    w_state_nxt = ST_RESP;
                end
            end
            ST_RESP: begin
                w_rsp_valid = 1'b1;
                if (rsp_ready) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Bus, latency counter, response and error registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op       <= OP_WR;
            r_lat_cnt  <= '0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_rsp_data <= '0;
            r_rsp_port <= 1'b0;
            r_err      <= 1'b0;
            r_rdy_en   <= 1'b0;
        end else begin
            r_rdy_en <= 1'b1;
            if (w_pop) begin
                r_op    <= w_head_op;
                r_addr  <= w_head_addr;
                r_wdata <= w_head_data;
                if (w_head_op == OP_RSV) begin
                    r_err <= 1'b1;
                end
            end
            if (r_state == ST_RD_WAIT && !w_lat_done) begin
                r_lat_cnt <= r_lat_cnt + 1'b1;
            end else begin
                r_lat_cnt <= '0;
            end
            if (w_lat_done) begin
                r_rsp_data <= (r_op == OP_RDB) ? mem_rdata_b : mem_rdata_a;
                r_rsp_port <= (r_op == OP_RDB);
            end
        end
    end

    assign iAddress     = r_addr;
    assign validdata    = r_wdata;
    assign iWriteEnable = w_we;
    assign Readtoa      = w_rda;
    assign Readtob      = w_rdb;
    assign rsp_valid    = w_rsp_valid;
    assign rsp_data     = r_rsp_data;
    assign rsp_port     = r_rsp_port;
    assign err_illegal  = r_err;

endmodule
